calc_seq_divider: RTL and testbench

//   Multi-cycle restoring integer divider for the calculator datapath; one quotient bit per clock.

---
 rtl/calc_seq_divider.sv | 153 +++++++++++++++
 tb/tb_calc_seq_divider.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_seq_divider.sv
`default_nettype none
// ============================================================================
// Module   : calc_seq_divider
// Purpose  : Multi-cycle restoring integer divider. It produces one quotient
//            bit per clock. The results feed the calculator result mux:
//            quotient drives the divide input and remainder drives the
//            modulo input.
// Ports    : clk, rst_n (async, active low)
//            start, dividend, divisor   - request and operands, sampled
//                                          on the accepting edge
//            busy, done                 - RUN indicator, 1-cycle done pulse
//            quotient, remainder        - registered results, held
//            div_by_zero                - divisor was zero, held with results
// Config   : CALC_DIV_SIGNED_EN - two's complement operands with truncating
//            division. When it is undefined, the divider is purely unsigned.
// Revision : 1.0 - initial release
// ============================================================================
module calc_seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] dvd_q;    // dividend shift register; quotient bits enter at LSB
  logic [WIDTH-1:0] dvs_q;    // latched divisor (magnitude)
  logic [WIDTH:0]   prem_q;   // partial remainder
  logic             busy_q, done_q, dbz_q;
  logic [WIDTH-1:0] quo_q, rem_q;

  logic             accept;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH:0]   shift_d, diff_d, prem_d;
  logic             fit_d;
  logic [WIDTH-1:0] dvd_d, quo_fin, rem_fin;

  assign accept = start && (state_q == ST_IDLE || state_q == ST_DONE);

  // Shift the next dividend bit into the partial remainder and trial-subtract.
  // The partial remainder is always below the divisor, so a negative
  // difference always shows up as the MSB of the WIDTH+1 bit result.
  assign shift_d = {prem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
  assign diff_d  = shift_d - {1'b0, dvs_q};
  assign fit_d   = ~diff_d[WIDTH];
  assign prem_d  = fit_d ? diff_d : shift_d;
  assign dvd_d   = {dvd_q[WIDTH-2:0], fit_d};

`ifdef CALC_DIV_SIGNED_EN
  logic neg_q_q, neg_r_q;
  // The magnitude of MIN_INT is 2^(WIDTH-1), which still fits as unsigned.
  assign dvd_mag = dividend[WIDTH-1] ? -dividend : dividend;
  assign dvs_mag = divisor[WIDTH-1]  ? -divisor  : divisor;
  assign quo_fin = neg_q_q ? -dvd_d : dvd_d;
  assign rem_fin = neg_r_q ? -prem_d[WIDTH-1:0] : prem_d[WIDTH-1:0];
`else
  assign dvd_mag = dividend;
  assign dvs_mag = divisor;
  assign quo_fin = dvd_d;
  assign rem_fin = prem_d[WIDTH-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      prem_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
`ifdef CALC_DIV_SIGNED_EN
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
`endif
    end else if (accept) begin
      if (divisor == '0) begin
        // A zero divisor completes immediately. Its result is all ones and the dividend.
        state_q <= ST_DONE;
        busy_q  <= 1'b0;
        done_q  <= 1'b1;
        dbz_q   <= 1'b1;
        quo_q   <= '1;
        rem_q   <= dividend;
      end else begin
        state_q <= ST_RUN;
        busy_q  <= 1'b1;
        done_q  <= 1'b0;
        dbz_q   <= 1'b0;
        count_q <= '0;
        prem_q  <= '0;
        dvd_q   <= dvd_mag;
        dvs_q   <= dvs_mag;
`ifdef CALC_DIV_SIGNED_EN
        neg_q_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
        neg_r_q <= dividend[WIDTH-1];
`endif
      end
    end else begin
      case (state_q)
        ST_RUN: begin
          prem_q  <= prem_d;
          dvd_q   <= dvd_d;
          count_q <= count_q + CW'(1);
          if (count_q == CW'(WIDTH - 1)) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            quo_q   <= quo_fin;
            rem_q   <= rem_fin;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_calc_seq_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_calc_seq_divider
// Purpose  : Self-checking bench for calc_seq_divider (WIDTH=32). It uses an
//            arithmetic reference model built on the / and % operators.
// Revision : 1.0 - initial release
// ============================================================================
module tb_calc_seq_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;

  int checks = 0;
  int failures = 0;
  logic [31:0] prev_q = '0;
  logic [31:0] prev_r = '0;

  calc_seq_divider #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r,
                                output logic dz);
    int sa, sb;
    dz = (b == 0);
    sa = a;
    sb = b;
    if (b == 0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else begin
`ifdef CALC_DIV_SIGNED_EN
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = a;
        r = 0;
      end else begin
        q = sa / sb;
        r = sa % sb;
      end
`else
      q = a / b;
      r = a % b;
`endif
    end
  endfunction

  // Called at a negedge. It drives one request, follows it to done and
  // checks latency, busy and the results. It returns at the negedge of the
  // done cycle, so an immediate second call issues a back-to-back start.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input int ign_at);
    logic [31:0] eq, er;
    logic        edz;
    int lat, busy_n, exp_lat;
    model(a, b, eq, er, edz);
    exp_lat = (b == 0) ? 1 : 33;
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0; dividend = $urandom; divisor = $urandom;
    lat = 1; busy_n = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (busy === 1'b1) busy_n++;
      if (lat == 1) begin
        checks++;
        if (div_by_zero !== 1'b0 || quotient !== prev_q || remainder !== prev_r) begin
          failures++;
          $display("FAIL accept_hold a=%h b=%h: dz=%b q=%h r=%h, required dz=0 q=%h r=%h",
                   a, b, div_by_zero, quotient, remainder, prev_q, prev_r);
        end
      end
      if (lat == ign_at) begin
        start = 1'b1; dividend = 32'd5; divisor = 32'd5;
      end else begin
        start = 1'b0; dividend = $urandom; divisor = $urandom;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    checks++;
    if (lat != exp_lat || busy_n != exp_lat - 1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL latency a=%h b=%h: done at %0d busy cycles %0d busy_at_done %b, required %0d / %0d / 0",
               a, b, lat, busy_n, busy, exp_lat, exp_lat - 1);
    end
    checks++;
    if (quotient !== eq || remainder !== er || div_by_zero !== edz) begin
      failures++;
      $display("FAIL result a=%h b=%h: q=%h r=%h dz=%b, required q=%h r=%h dz=%b",
               a, b, quotient, remainder, div_by_zero, eq, er, edz);
    end
    prev_q = eq;
    prev_r = er;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 0 || done !== 0 || quotient !== 0 || remainder !== 0 || div_by_zero !== 0) begin
      failures++;
      $display("FAIL reset_state: busy=%b done=%b q=%h r=%h dz=%b, required all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    do_op(32'd245, 32'd127, 0);
    checks++;
    if (quotient !== 32'd1 || remainder !== 32'd118) begin
      failures++;
      $display("FAIL basic_245_127: q=%0d r=%0d, required q=1 r=118", quotient, remainder);
    end
    // Results must hold through the following IDLE cycles with done low.
    repeat (2) @(negedge clk);
    checks++;
    if (done !== 0 || busy !== 0 || quotient !== 32'd1 || remainder !== 32'd118) begin
      failures++;
      $display("FAIL hold_idle: done=%b busy=%b q=%0d r=%0d, required 0 0 1 118",
               done, busy, quotient, remainder);
    end
  endtask

  task automatic test_back_to_back;
    do_op(32'h1FF, 32'h155, 0);
    do_op(32'hFFFF_FFFF, 32'd1, 0);
    @(negedge clk);
  endtask

  task automatic test_div_zero;
    do_op(32'd100, 32'd0, 0);
    do_op(32'd9, 32'd3, 0);
    @(negedge clk);
  endtask

  task automatic test_ignore_start;
    do_op(32'd1000, 32'd7, 10);
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL ignored_start: done=%b busy=%b after completion, required 0 0", done, busy);
    end
    checks++;
    if (quotient !== 32'd142 || remainder !== 32'd6) begin
      failures++;
      $display("FAIL ignored_result: q=%0d r=%0d, required q=142 r=6", quotient, remainder);
    end
  endtask

  task automatic test_reset_mid_run;
    int seen_done;
    start = 1'b1; dividend = 32'd1000; divisor = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 0 || done !== 0 || quotient !== 0 || remainder !== 0 || div_by_zero !== 0) begin
      failures++;
      $display("FAIL reset_mid_run: busy=%b done=%b q=%h r=%h dz=%b, required all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen_done++;
    end
    checks++;
    if (seen_done != 0) begin
      failures++;
      $display("FAIL abort_no_done: %0d active cycles after reset, required 0", seen_done);
    end
    prev_q = '0;
    prev_r = '0;
    do_op(32'd6, 32'd4, 0);
    @(negedge clk);
  endtask

  task automatic test_random;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'd1;
        2: b = $urandom_range(2, 255);
        3: b = a + $urandom_range(1, 1000);
        4: b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      do_op(a, b, 0);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
  endtask

`ifdef CALC_DIV_SIGNED_EN
  task automatic test_signed;
    do_op(32'hFFFF_FFF9, 32'd2, 0);
    checks++;
    if (quotient !== 32'hFFFF_FFFD || remainder !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL signed_m7_2: q=%h r=%h, required q=fffffffd r=ffffffff", quotient, remainder);
    end
    do_op(32'd7, 32'hFFFF_FFFE, 0);
    checks++;
    if (quotient !== 32'hFFFF_FFFD || remainder !== 32'd1) begin
      failures++;
      $display("FAIL signed_7_m2: q=%h r=%h, required q=fffffffd r=1", quotient, remainder);
    end
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 0);
    checks++;
    if (quotient !== 32'h8000_0000 || remainder !== 32'd0) begin
      failures++;
      $display("FAIL signed_minint: q=%h r=%h, required q=80000000 r=0", quotient, remainder);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_div_zero();
    test_ignore_start();
    test_reset_mid_run();
`ifdef CALC_DIV_SIGNED_EN
    test_signed();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
